// File: rtl/piece_collision_ctrl.sv
// Walks the 16 cells of a 4x4 piece bitmap, checking each set cell against the board
// bounds and the board RAM, and reports whether the piece collides.
module piece_collision_ctrl #(
  parameter int BOARD_W  = 10,
  parameter int BOARD_H  = 20,
  parameter int ADDR_W   = 8,
  parameter int COLOUR_W = 6,
  parameter int RAM_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          origin_x,
  input  logic [6:0]          origin_y,
  input  logic [15:0]         mask,
  input  logic [COLOUR_W-1:0] ram_q,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_rd,
  output logic                busy,
  output logic                done,
  output logic                hit
);

  localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          idx_reg, idx_next;
  logic [7:0]          origin_x_reg, origin_x_next;
  logic [6:0]          origin_y_reg, origin_y_next;
  logic [15:0]         mask_reg, mask_next;
  logic [LAT_W-1:0]    wait_cnt_reg, wait_cnt_next;
  logic                hit_reg, hit_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                ram_rd_reg, ram_rd_next;
  logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
  logic                cur_set, cur_oob, nxt_set, nxt_oob;

  // The carry out of the 9-bit / 8-bit sums lands above the board, so it reads as out of bounds.
  function automatic logic cell_oob(input logic [7:0] ox, input logic [6:0] oy, input logic [3:0] i);
    logic [8:0] x;
    logic [7:0] y;
    x = {1'b0, ox} + {7'd0, i[1:0]};
    y = {1'b0, oy} + {6'd0, i[3:2]};
    return (x >= 9'(BOARD_W)) || (y >= 8'(BOARD_H));
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] ox, input logic [6:0] oy, input logic [3:0] i);
    logic [8:0] x;
    logic [7:0] y;
    x = {1'b0, ox} + {7'd0, i[1:0]};
    y = {1'b0, oy} + {6'd0, i[3:2]};
    return ADDR_W'(32'(y) * 32'(BOARD_W) + 32'(x));
  endfunction

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    origin_x_next = origin_x_reg;
    origin_y_next = origin_y_reg;
    mask_next     = mask_reg;
    wait_cnt_next = wait_cnt_reg;
    hit_next      = hit_reg;
    cur_set       = mask_reg[idx_reg];
    cur_oob       = cell_oob(origin_x_reg, origin_y_reg, idx_reg);

    case (state_reg)
      IDLE: begin
        if (start) begin
          origin_x_next = origin_x;
          origin_y_next = origin_y;
          mask_next     = mask;
          idx_next      = 4'd0;
          hit_next      = 1'b0;
          state_next    = SCAN;
        end
      end
      SCAN: begin
        if (!cur_set) begin
          if (idx_reg == 4'd15) state_next = DONE;
          else                  idx_next   = idx_reg + 4'd1;
        end else if (cur_oob) begin
          hit_next   = 1'b1;
          state_next = DONE;
        end else begin
          wait_cnt_next = '0;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_reg == LAT_W'(RAM_LAT - 1)) begin
          if (|ram_q) begin
            hit_next   = 1'b1;
            state_next = DONE;
          end else if (idx_reg == 4'd15) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 4'd1;
            state_next = SCAN;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Outputs are registered, so they are decided from the cell the next cycle will examine.
    nxt_set       = mask_next[idx_next];
    nxt_oob       = cell_oob(origin_x_next, origin_y_next, idx_next);
    busy_next     = (state_next == SCAN) || (state_next == WAIT);
    done_next     = (state_next == DONE);
    ram_rd_next   = (state_next == SCAN) && nxt_set && !nxt_oob;
    ram_addr_next = '0;
    if (ram_rd_next)               ram_addr_next = cell_addr(origin_x_next, origin_y_next, idx_next);
    else if (state_next == WAIT)   ram_addr_next = ram_addr_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      origin_x_reg <= '0;
      origin_y_reg <= '0;
      mask_reg     <= '0;
      wait_cnt_reg <= '0;
      hit_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ram_rd_reg   <= 1'b0;
      ram_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      origin_x_reg <= origin_x_next;
      origin_y_reg <= origin_y_next;
      mask_reg     <= mask_next;
      wait_cnt_reg <= wait_cnt_next;
      hit_reg      <= hit_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      ram_rd_reg   <= ram_rd_next;
      ram_addr_reg <= ram_addr_next;
    end
  end

  assign ram_addr = ram_addr_reg;
  assign ram_rd   = ram_rd_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign hit      = hit_reg;

endmodule

// File: tb/tb_piece_collision_ctrl.sv
// Bench for piece_collision_ctrl: fixed vector table, hand-written corner sequences and
// randomized checks against a cell-by-cell reference model with a 1-cycle board RAM.
module tb_piece_collision_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  origin_x;
  logic [6:0]  origin_y;
  logic [15:0] mask;
  logic [5:0]  ram_q = '0;
  logic [7:0]  ram_addr;
  logic        ram_rd;
  logic        busy;
  logic        done;
  logic        hit;

  piece_collision_ctrl #(
    .BOARD_W(10), .BOARD_H(20), .ADDR_W(8), .COLOUR_W(6), .RAM_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .origin_x(origin_x), .origin_y(origin_y),
    .mask(mask), .ram_q(ram_q), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .busy(busy), .done(done), .hit(hit)
  );

  always #5 clk = ~clk;

  logic [5:0] ram_mem [0:255];
  always @(posedge clk) if (ram_rd) ram_q <= ram_mem[ram_addr];

  int   n_vec;
  int   n_bad;
  int   got_cyc;
  logic got_hit;
  int   got_q[$];
  int   exp_cyc;
  logic exp_hit;
  int   exp_q[$];

  typedef struct {
    logic [15:0] m;
    int          ox;
    int          oy;
    int          nz;     // address of the one occupied board cell, -1 for an empty board
    logic        hit;
    int          cyc;    // cycle index of done, counting the start cycle as 0
    int          reads;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 256; i++) ram_mem[i] = 6'd0;
  endtask

  // Walk the cells in order: each costs one scan cycle, an in-bounds set cell adds a read.
  task automatic ref_model(input logic [15:0] m, input int ox, input int oy);
    exp_q.delete();
    exp_hit = 1'b0;
    exp_cyc = 1;
    for (int i = 0; i < 16; i++) begin
      int x = ox + (i % 4);
      int y = oy + (i / 4);
      exp_cyc++;
      if (m[i]) begin
        if (x >= 10 || y >= 20) begin
          exp_hit = 1'b1;
          break;
        end
        exp_q.push_back(y * 10 + x);
        exp_cyc += 1;
        if (ram_mem[y * 10 + x] != 6'd0) begin
          exp_hit = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic run_check(input logic [15:0] m, input int ox, input int oy,
                           input int glitch_cyc, input bit pulse_in_done, input logic exp_h);
    bit prev_rd;
    int prev_addr;
    bit finished;
    got_q.delete();
    got_hit   = 1'b0;
    got_cyc   = -1;
    finished  = 1'b0;
    prev_rd   = 1'b0;
    prev_addr = 0;
    @(negedge clk);
    mask = m; origin_x = 8'(ox); origin_y = 7'(oy); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("hit_cleared_on_start", hit, 0);
      if (done) begin
        finished = 1'b1;
        got_cyc  = cyc;
        got_hit  = hit;
        start    = 1'b0;
        check("busy_in_done", busy, 0);
        check("addr_in_done", ram_addr, 0);
        if (pulse_in_done) begin
          mask = 16'hFFFF; origin_x = 8'd200; start = 1'b1;
        end
      end else begin
        check("busy_during_check", busy, 1);
        if (ram_rd)       got_q.push_back(int'(ram_addr));
        else if (prev_rd) check("addr_held_in_wait", ram_addr, prev_addr);
        else              check("addr_zero_no_read", ram_addr, 0);
        prev_rd   = ram_rd;
        prev_addr = int'(ram_addr);
        if (cyc == glitch_cyc) begin
          mask = 16'hFFFF; origin_x = 8'd200; origin_y = 7'd100; start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
    end
    if (!finished) check("done_timeout", 0, 1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("hit_held", hit, exp_h);
  endtask

  task automatic compare_reads();
    check("read_count", got_q.size(), exp_q.size());
    if (got_q.size() == exp_q.size())
      foreach (exp_q[k]) check("read_addr", got_q[k], exp_q[k]);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1; start = 1'b0; mask = '0; origin_x = '0; origin_y = '0;
    clear_ram();

    tbl[0] = '{16'h0001,   0,   0,  -1, 1'b0, 18,  1};
    tbl[1] = '{16'h0072,   3,   5,  63, 1'b1,  8,  2};
    tbl[2] = '{16'h0004,   8,   0,  -1, 1'b1,  4,  0};
    tbl[3] = '{16'h0000,   0,   0,  -1, 1'b0, 17,  0};
    tbl[4] = '{16'h0100,   0,  18,  -1, 1'b1, 10,  0};
    tbl[5] = '{16'h0100,   0,  17,  -1, 1'b0, 18,  1};
    tbl[6] = '{16'hFFFF,   0,   0,  -1, 1'b0, 33, 16};
    tbl[7] = '{16'h8000, 255, 127,  -1, 1'b1, 17,  0};
    tbl[8] = '{16'h0008,   7,   0,  -1, 1'b1,  5,  0};
    tbl[9] = '{16'h0008,   6,  16, 169, 1'b1,  6,  1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hit", hit, 0);
    check("reset_ram_rd", ram_rd, 0);
    check("reset_ram_addr", ram_addr, 0);
    reset = 1'b0;

    for (int t = 0; t < 10; t++) begin
      clear_ram();
      if (tbl[t].nz >= 0) ram_mem[tbl[t].nz] = 6'h2A;
      ref_model(tbl[t].m, tbl[t].ox, tbl[t].oy);
      run_check(tbl[t].m, tbl[t].ox, tbl[t].oy, 0, 1'b0, tbl[t].hit);
      check("tbl_hit", got_hit, tbl[t].hit);
      check("tbl_done_cycle", got_cyc, tbl[t].cyc);
      check("tbl_reads", got_q.size(), tbl[t].reads);
      compare_reads();
      $display("table %0d: mask=%h org=(%0d,%0d) hit=%0d done_cycle=%0d reads=%0d",
               t, tbl[t].m, tbl[t].ox, tbl[t].oy, got_hit, got_cyc, got_q.size());
    end

    // start pulsed mid-scan and during DONE must both be ignored
    clear_ram();
    run_check(16'h0000, 0, 0, 5, 1'b1, 1'b0);
    check("glitch_hit", got_hit, 0);
    check("glitch_done_cycle", got_cyc, 17);
    check("glitch_reads", got_q.size(), 0);
    $display("ignored starts: hit=%0d done_cycle=%0d", got_hit, got_cyc);

    // reset while waiting on the RAM, then a normal check
    @(negedge clk);
    mask = 16'h0001; origin_x = 8'd0; origin_y = 7'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("pre_reset_rd", ram_rd, 1);
    @(negedge clk);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_hit", hit, 0);
    check("midreset_ram_rd", ram_rd, 0);
    check("midreset_ram_addr", ram_addr, 0);
    ram_mem[0] = 6'h01;
    run_check(16'h0001, 0, 0, 0, 1'b0, 1'b1);
    check("after_reset_hit", got_hit, 1);
    check("after_reset_done_cycle", got_cyc, 3);
    $display("reset in WAIT then restart: hit=%0d done_cycle=%0d", got_hit, got_cyc);

    for (int r = 0; r < 40; r++) begin
      logic [15:0] m;
      int ox;
      int oy;
      for (int i = 0; i < 256; i++)
        ram_mem[i] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      m  = ($urandom_range(0, 1) == 0) ? 16'($urandom & $urandom) : 16'($urandom);
      ox = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 11)) : int'($urandom_range(0, 255));
      oy = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 21)) : int'($urandom_range(0, 127));
      ref_model(m, ox, oy);
      run_check(m, ox, oy, 0, 1'b0, exp_hit);
      check("rand_hit", got_hit, exp_hit);
      check("rand_done_cycle", got_cyc, exp_cyc);
      compare_reads();
      $display("random %0d: mask=%h org=(%0d,%0d) hit=%0d done_cycle=%0d reads=%0d",
               r, m, ox, oy, got_hit, got_cyc, got_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
